conv_piso: RTL and testbench

// - Parallel-in, serial-out converter for the wake-word datapath.
// - Accepts one column of COLUMN_LEN signed BW-bit elements per valid/ready handshake.
// - Replays the column one element per cycle on a BW-wide valid/ready/last stream.
// - Sits downstream of conv/dense column producers. Feeds scalar consumers (argmax, serial out).
// - Frame boundaries are carried on last_i and last_o.

---
 rtl/conv_piso_pkg.sv | 25 ++
 rtl/conv_piso_buf.sv | 67 ++++++
 rtl/conv_piso.sv | 105 ++++++++++
 tb/tb_conv_piso.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_piso_pkg.sv
// Shared defaults and frame-check helpers for the wake-word parallel-to-serial converter.
package conv_piso_pkg;

    localparam int BW_DEFAULT         = 8;
    localparam int COLUMN_LEN_DEFAULT = 8;
    localparam int FRAME_LEN_DEFAULT  = 50;

    typedef enum logic [1:0] {
        FRAME_CONTINUE,
        FRAME_CLOSE,
        FRAME_ERROR
    } frame_evt_e;

    // A frame closes cleanly only when last arrives exactly on the final column slot.
    function automatic frame_evt_e frame_event(input logic last, input logic at_end);
        if (last) begin
            return at_end ? FRAME_CLOSE : FRAME_ERROR;
        end
        if (at_end) begin
            return FRAME_ERROR;
        end
        return FRAME_CONTINUE;
    endfunction

endpackage

// File: rtl/conv_piso_buf.sv
// Two-entry ping-pong column buffer; the write slot is free exactly when its full flag is clear.
module conv_piso_buf #(
    parameter int W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_valid_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         wr_last_i,
    output logic         wr_ready_o,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    output logic         rd_last_o,
    input  logic         rd_release_i
);

    logic [1:0]        full_q, full_d;
    logic [1:0]        last_q, last_d;
    logic [1:0][W-1:0] data_q, data_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_en;
    logic              rd_en;

    assign wr_ready_o = !full_q[wr_ptr_q];
    assign wr_en      = wr_valid_i && wr_ready_o;
    assign rd_valid_o = full_q[rd_ptr_q];
    assign rd_en      = rd_release_i && rd_valid_o;
    assign rd_data_o  = data_q[rd_ptr_q];
    assign rd_last_o  = last_q[rd_ptr_q];

    // Write and release always hit different entries, so both may land in one cycle.
    always_comb begin
        full_d   = full_q;
        last_d   = last_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            data_d[wr_ptr_q] = wr_data_i;
            last_d[wr_ptr_q] = wr_last_i;
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = !wr_ptr_q;
        end
        if (rd_en) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = !rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q   <= '0;
            last_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            last_q   <= last_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/conv_piso.sv
// Column-in, element-out converter: replays each buffered column one signed element per cycle
// and checks that frames carry exactly FRAME_LEN columns.
module conv_piso
    import conv_piso_pkg::*;
#(
    parameter int BW         = BW_DEFAULT,
    parameter int COLUMN_LEN = COLUMN_LEN_DEFAULT,
    parameter int FRAME_LEN  = FRAME_LEN_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [COLUMN_LEN*BW-1:0] data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic [BW-1:0]            data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i,
    output logic                     frame_err_o
);

    localparam int EW = (COLUMN_LEN > 1) ? $clog2(COLUMN_LEN) : 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [COLUMN_LEN*BW-1:0] col_data;
    logic                     col_last;
    logic                     accept;
    logic                     xfer;
    logic                     elem_last;
    logic                     release_col;
    logic [EW-1:0]            elem_cnt_q, elem_cnt_d;
    logic [CW-1:0]            col_cnt_q, col_cnt_d;
    logic                     frame_err_q, frame_err_d;
    frame_evt_e               evt;

    conv_piso_buf #(
        .W(COLUMN_LEN*BW)
    ) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_valid_i   (valid_i),
        .wr_data_i    (data_i),
        .wr_last_i    (last_i),
        .wr_ready_o   (ready_o),
        .rd_valid_o   (valid_o),
        .rd_data_o    (col_data),
        .rd_last_o    (col_last),
        .rd_release_i (release_col)
    );

    assign accept      = valid_i && ready_o;
    assign xfer        = valid_o && ready_i;
    assign elem_last   = (elem_cnt_q == EW'(COLUMN_LEN - 1));
    assign release_col = xfer && elem_last;
    assign last_o      = valid_o && col_last && elem_last;
    assign frame_err_o = frame_err_q;

    always_comb begin
        data_o = '0;
        for (int k = 0; k < COLUMN_LEN; k++) begin
            if (elem_cnt_q == EW'(k)) begin
                data_o = col_data[k*BW +: BW];
            end
        end
    end

    always_comb begin
        elem_cnt_d = elem_cnt_q;
        if (xfer) begin
            elem_cnt_d = elem_last ? '0 : elem_cnt_q + EW'(1);
        end
    end

    // Malformed frames resynchronise the column count at the offending accept.
    always_comb begin
        col_cnt_d   = col_cnt_q;
        frame_err_d = 1'b0;
        evt         = frame_event(last_i, col_cnt_q == CW'(FRAME_LEN - 1));
        if (accept) begin
            case (evt)
                FRAME_CONTINUE: col_cnt_d = col_cnt_q + CW'(1);
                FRAME_CLOSE:    col_cnt_d = '0;
                FRAME_ERROR: begin
                    col_cnt_d   = '0;
                    frame_err_d = 1'b1;
                end
                default:        col_cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            elem_cnt_q  <= '0;
            col_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            elem_cnt_q  <= elem_cnt_d;
            col_cnt_q   <= col_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_conv_piso.sv
// Self-checking bench for conv_piso: directed vector table, hand sequences for reset, frames and
// backpressure, plus a COLUMN_LEN=1 / BW=16 instance.
module tb_conv_piso;

    localparam int BW = 8;
    localparam int CL = 8;
    localparam int FL = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [CL*BW-1:0] data_i;
    logic          valid_i, last_i, ready_o;
    logic [BW-1:0] data_o;
    logic          valid_o, last_o, ready_i, frame_err_o;

    logic [15:0]   n_data_i, n_data_o;
    logic          n_valid_i, n_last_i, n_ready_o, n_valid_o, n_last_o, n_ready_i, n_frame_err_o;

    always #5 clk = ~clk;

    conv_piso #(.BW(BW), .COLUMN_LEN(CL), .FRAME_LEN(FL)) u_dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .ready_i(ready_i), .frame_err_o(frame_err_o)
    );

    conv_piso #(.BW(16), .COLUMN_LEN(1), .FRAME_LEN(FL)) u_dut_narrow (
        .clk_i(clk), .rst_i(rst), .data_i(n_data_i), .valid_i(n_valid_i), .last_i(n_last_i),
        .ready_o(n_ready_o), .data_o(n_data_o), .valid_o(n_valid_o), .last_o(n_last_o),
        .ready_i(n_ready_i), .frame_err_o(n_frame_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: expected element stream, column occupancy and frame-error pulse.
    typedef struct packed {
        logic [BW-1:0] data;
        logic          last;
    } elem_t;

    elem_t exp_q[$];
    elem_t e;
    int    held = 0, out_in_col = 0, col_model = 0;
    logic  exp_err = 1'b0, nxt_err;
    bit    rand_ready = 0;
    int    cycle = 0, out_elems = 0, last_count = 0, last_index = 0, err_count = 0;
    int    first_xfer = -1, last_xfer = -1;
    logic  acc, rel;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held = 0; out_in_col = 0; col_model = 0; exp_err = 1'b0;
        end else begin
            cycle++;
            if (rand_ready) ready_i = ($urandom_range(0, 1) == 1);
            checkOutput("ready_o vs occupancy", ready_o, held < 2);
            checkOutput("valid_o vs occupancy", valid_o, held > 0);
            checkOutput("frame_err_o pulse", frame_err_o, exp_err);
            if (frame_err_o) err_count++;
            if (valid_o && exp_q.size() > 0) begin
                checkOutput("data_o stream", data_o, exp_q[0].data);
                checkOutput("last_o stream", last_o, exp_q[0].last);
            end
            acc = valid_i && ready_o;
            rel = 1'b0;
            if (valid_o && ready_i) begin
                out_elems++;
                if (last_o) begin
                    last_count++;
                    last_index = out_elems;
                end
                if (first_xfer < 0) first_xfer = cycle;
                last_xfer = cycle;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                out_in_col++;
                if (out_in_col == CL) begin
                    out_in_col = 0;
                    rel = 1'b1;
                end
            end
            nxt_err = 1'b0;
            if (acc) begin
                for (int k = 0; k < CL; k++) begin
                    e.data = data_i[k*BW +: BW];
                    e.last = last_i && (k == CL - 1);
                    exp_q.push_back(e);
                end
                if (last_i) begin
                    nxt_err = (col_model != FL - 1);
                    col_model = 0;
                end else if (col_model == FL - 1) begin
                    nxt_err = 1'b1;
                    col_model = 0;
                end else begin
                    col_model++;
                end
            end
            exp_err = nxt_err;
            held = held + (acc ? 1 : 0) - (rel ? 1 : 0);
        end
    end

    // Called and returns at posedge+1; returns one step after the accepting edge.
    task automatic applyStimulus(input logic [63:0] col, input logic last);
        int budget = 0;
        data_i  = col;
        last_i  = last;
        valid_i = 1'b1;
        while (!ready_o && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: ready_o=%0b, required 1", ready_o);
        end else begin
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drainWait();
        int budget = 0;
        while ((exp_q.size() != 0 || valid_o) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("drain leftover elements", exp_q.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ready_o"}, ready_o, 1);
        checkOutput({tag, " valid_o"}, valid_o, 0);
        checkOutput({tag, " last_o"}, last_o, 0);
        checkOutput({tag, " frame_err_o"}, frame_err_o, 0);
        checkOutput({tag, " data_o"}, data_o, 0);
    endtask

    typedef struct {
        logic [63:0] column;
        logic        last;
        logic [63:0] exp_seq;   // first element in the top byte
        logic        exp_err;
    } vec_t;

    vec_t        vecs[4];
    logic [63:0] col;
    logic [15:0] prev_n;

    initial begin
        vecs[0] = '{64'h0706050403020100, 1'b0, 64'h0001020304050607, 1'b0};
        vecs[1] = '{64'h8081FE7F00FF1234, 1'b0, 64'h3412FF007FFE8180, 1'b0};
        vecs[2] = '{64'hDEADBEEFCAFEF00D, 1'b1, 64'h0DF0FECAEFBEADDE, 1'b1};
        vecs[3] = '{64'h0123456789ABCDEF, 1'b0, 64'hEFCDAB8967452301, 1'b0};

        rst = 1'b1; data_i = '0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b1;
        n_data_i = '0; n_valid_i = 1'b0; n_last_i = 1'b0; n_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("in reset");
        rst = 1'b0;
        @(posedge clk); #1;
        checkResetOutputs("after reset");

        $display("[TB] directed column table");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].column, vecs[i].last);
            checkOutput("table frame_err_o", frame_err_o, vecs[i].exp_err);
            for (int k = 0; k < CL; k++) begin
                checkOutput("table valid_o", valid_o, 1);
                checkOutput("table data_o", data_o, vecs[i].exp_seq[63-8*k -: 8]);
                checkOutput("table last_o", last_o, vecs[i].last && (k == CL - 1));
                @(posedge clk); #1;
            end
            checkOutput("table empty after column", valid_o, 0);
        end

        $display("[TB] reset mid-column");
        applyStimulus(64'h0706050403020100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre-reset element 3", data_o, 8'h03);
        rst = 1'b1;
        #1;
        checkResetOutputs("async reset");
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetOutputs("post mid reset");
        applyStimulus(64'h1716151413121110, 1'b0);
        checkOutput("restart element 0", data_o, 8'h10);
        drainWait();

        $display("[TB] back-to-back frame of 50 columns");
        doReset();
        out_elems = 0; last_count = 0; last_index = 0; err_count = 0; first_xfer = -1; last_xfer = -1;
        for (int i = 0; i < FL; i++) begin
            for (int k = 0; k < CL; k++) col[k*8 +: 8] = 8'(i * 8 + k);
            applyStimulus(col, i == FL - 1);
        end
        drainWait();
        checkOutput("frame element count", out_elems, 400);
        checkOutput("frame last_o count", last_count, 1);
        checkOutput("frame last_o position", last_index, 400);
        checkOutput("frame error count", err_count, 0);
        checkOutput("frame contiguous span", last_xfer - first_xfer, 399);

        $display("[TB] frame error: last on column 10");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(64'(i) * 64'h0101010101010101, i == 9);
            if (i == 8) checkOutput("no pulse before short last", frame_err_o, 0);
        end
        checkOutput("short frame pulse", frame_err_o, 1);
        @(posedge clk); #1;
        checkOutput("short frame pulse width", frame_err_o, 0);
        drainWait();

        $display("[TB] frame error: 51 columns without last");
        doReset();
        for (int i = 0; i < FL + 1; i++) begin
            applyStimulus({56'h0, 8'(i)}, 1'b0);
            if (i == FL - 2) checkOutput("no pulse at column 49", frame_err_o, 0);
            if (i == FL - 1) checkOutput("long frame pulse", frame_err_o, 1);
            if (i == FL) checkOutput("no pulse at column 51", frame_err_o, 0);
        end
        drainWait();

        $display("[TB] random backpressure");
        doReset();
        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            col = {$urandom(), $urandom()};
            applyStimulus(col, i == 19);
        end
        drainWait();
        rand_ready = 0;
        ready_i = 1'b1;
        @(posedge clk); #1;

        $display("[TB] COLUMN_LEN=1, BW=16 instance");
        for (int i = 0; i < 10; i++) begin
            checkOutput("narrow ready_o", n_ready_o, 1);
            n_data_i  = (i % 2 == 0) ? (16'hA500 + 16'(i)) : (16'h5A00 + 16'(i));
            n_valid_i = 1'b1;
            prev_n    = n_data_i;
            @(posedge clk); #1;
            checkOutput("narrow valid_o", n_valid_o, 1);
            checkOutput("narrow data_o", n_data_o, prev_n);
            checkOutput("narrow last_o", n_last_o, 0);
            checkOutput("narrow frame_err_o", n_frame_err_o, 0);
        end
        n_valid_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("narrow drained", n_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global timeout: simulation still running, required finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
